// File: rtl/led_pio_sequencer.sv
// Autonomous LED pattern sequencer: an Avalon-MM config slave plus a write master
// that steps PIO data through up to NUM_STEPS patterns with a programmable dwell.
module led_pio_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_STEPS    = 4,
  parameter int PERIOD_WIDTH = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  output logic        busy,
  output logic        done_irq
);

  localparam int STEP_W = $clog2(NUM_STEPS);

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, HOLD = 2'd2} state_t;

  state_t                  state, state_next;
  logic                    run, loop_en, irq_en, done;
  logic [PERIOD_WIDTH-1:0] period, period_eff, cnt, cnt_next;
  logic [4:0]              length, eff_len, addr_ext;
  logic [DATA_WIDTH-1:0]   pattern [NUM_STEPS];
  logic [DATA_WIDTH-1:0]   data_q;
  logic [STEP_W-1:0]       step, step_next, pat_idx;
  logic                    wr, ctrl_wr, status_wr, start, stop_req, last_step;
  logic                    pat_sel, load, set_done, clear_run;

  assign wr        = s_chipselect & ~s_write_n;
  assign ctrl_wr   = wr && (s_address == 4'd0);
  assign status_wr = wr && (s_address == 4'd1);
  assign addr_ext  = {1'b0, s_address};
  assign pat_sel   = (addr_ext >= 5'd4) && (addr_ext < 5'(4 + NUM_STEPS));
  assign pat_idx   = STEP_W'(addr_ext - 5'd4);

  assign start      = ctrl_wr && s_writedata[0] && (state == IDLE);
  // A CTRL write clearing RUN stops the run at the same edge it is captured.
  assign stop_req   = ~run | (ctrl_wr & ~s_writedata[0]);
  assign period_eff = (period == '0) ? PERIOD_WIDTH'(1) : period;
  assign last_step  = (5'(step) + 5'd1) >= eff_len;

  always_comb begin
    eff_len = length;
    if (length == 5'd0)
      eff_len = 5'd1;
    else if (length > 5'(NUM_STEPS))
      eff_len = 5'(NUM_STEPS);
  end

  always_comb begin
    state_next = state;
    step_next  = step;
    cnt_next   = cnt;
    load       = 1'b0;
    set_done   = 1'b0;
    clear_run  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = WRITE;
          step_next  = '0;
          load       = 1'b1;
        end
      end
      WRITE: begin
        if (!m_waitrequest) begin
          state_next = stop_req ? IDLE : HOLD;
          cnt_next   = period_eff - PERIOD_WIDTH'(1);
        end
      end
      HOLD: begin
        if (stop_req) begin
          state_next = IDLE;
        end else if (cnt == '0) begin
          if (!last_step) begin
            step_next  = step + STEP_W'(1);
            state_next = WRITE;
            load       = 1'b1;
          end else if (loop_en) begin
            step_next  = '0;
            state_next = WRITE;
            load       = 1'b1;
          end else begin
            step_next  = '0;
            state_next = IDLE;
            set_done   = 1'b1;
            clear_run  = 1'b1;
          end
        end else begin
          cnt_next = cnt - PERIOD_WIDTH'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pattern data is latched on WRITE entry so it stays stable through a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      step   <= '0;
      cnt    <= '0;
      data_q <= '0;
    end else begin
      state <= state_next;
      step  <= step_next;
      cnt   <= cnt_next;
      if (load)
        data_q <= pattern[step_next];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run     <= 1'b0;
      loop_en <= 1'b0;
      irq_en  <= 1'b0;
      done    <= 1'b0;
      period  <= PERIOD_WIDTH'(1);
      length  <= 5'(NUM_STEPS);
      for (int i = 0; i < NUM_STEPS; i++)
        pattern[i] <= '0;
    end else begin
      if (ctrl_wr) begin
        loop_en <= s_writedata[1];
        irq_en  <= s_writedata[2];
        if (state == IDLE)
          run <= s_writedata[0];
        else if (!s_writedata[0])
          run <= 1'b0;
      end
      if (clear_run)
        run <= 1'b0;
      if (set_done)
        done <= 1'b1;
      else if (status_wr)
        done <= 1'b0;
      if (wr && (s_address == 4'd2))
        period <= s_writedata[PERIOD_WIDTH-1:0];
      if (wr && (s_address == 4'd3))
        length <= s_writedata[4:0];
      if (wr && pat_sel)
        pattern[pat_idx] <= s_writedata[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    s_readdata = '0;
    case (s_address)
      4'd0:    s_readdata = {29'd0, irq_en, loop_en, run};
      4'd1:    s_readdata = {20'd0, 4'(step), 6'd0, done, busy};
      4'd2:    s_readdata = 32'(period);
      4'd3:    s_readdata = {27'd0, length};
      default: if (pat_sel) s_readdata = 32'(pattern[pat_idx]);
    endcase
  end

  assign busy         = (state != IDLE);
  assign done_irq     = done & irq_en;
  assign m_address    = 2'd0;
  assign m_chipselect = (state == WRITE);
  assign m_write_n    = (state != WRITE);
  assign m_writedata  = (state == WRITE) ? 32'(data_q) : 32'd0;

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Self-checking bench for led_pio_sequencer: register table vectors plus
// hand-written multi-cycle sequences checked against a PIO write log.
module tb_led_pio_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  s_address;
  logic        s_chipselect;
  logic        s_write_n;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        m_waitrequest;
  logic        busy;
  logic        done_irq;

  led_pio_sequencer dut (
    .clk(clk), .reset(reset),
    .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
    .s_writedata(s_writedata), .s_readdata(s_readdata),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest),
    .busy(busy), .done_irq(done_irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Every accepted PIO write is logged with the cycle it completed in.
  logic [31:0] log_data [$];
  int          log_cyc [$];
  always @(negedge clk) begin
    if (!reset && m_chipselect && !m_write_n && !m_waitrequest) begin
      log_data.push_back(m_writedata);
      log_cyc.push_back(cyc);
    end
  end

  int total  = 0;
  int passed = 0;

  typedef struct {
    string       name;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    s_chipselect = 1'b1;
    s_write_n    = 1'b0;
    s_address    = addr;
    s_writedata  = data;
    @(posedge clk); #1;
    s_chipselect = 1'b0;
    s_write_n    = 1'b1;
    s_writedata  = '0;
  endtask

  task automatic checkReg(input string name, input logic [3:0] addr, input logic [31:0] exp);
    s_address = addr;
    #1;
    checkOutput(name, s_readdata, exp);
  endtask

  task automatic readReg(input logic [3:0] addr, output logic [31:0] data);
    s_address = addr;
    #1;
    data = s_readdata;
  endtask

  task automatic waitIdle(input int max_cycles, input string name);
    int n = 0;
    while (busy && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic waitWrites(input int count, input int max_cycles, input string name);
    int n = 0;
    while (log_data.size() < count && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(name, {31'd0, log_data.size() >= count}, 32'd1);
  endtask

  task automatic clearLog();
    log_data.delete();
    log_cyc.delete();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          t0;
    int          n;
    logic [31:0] rd;
    logic [31:0] exp_pat [4];

    exp_pat[0] = 32'h01; exp_pat[1] = 32'h02; exp_pat[2] = 32'h04; exp_pat[3] = 32'h08;

    vecs[0] = '{"period_trunc",  4'd2,  32'h1234_5678, 32'h0034_5678};
    vecs[1] = '{"period_zero",   4'd2,  32'h0000_0000, 32'h0000_0000};
    vecs[2] = '{"length_5bit",   4'd3,  32'h0000_00FF, 32'h0000_001F};
    vecs[3] = '{"pattern0",      4'd4,  32'h0000_01A5, 32'h0000_00A5};
    vecs[4] = '{"pattern3",      4'd7,  32'hFFFF_FF3C, 32'h0000_003C};
    vecs[5] = '{"unmapped8",     4'd8,  32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6] = '{"unmapped15",    4'd15, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7] = '{"ctrl_loop_irq", 4'd0,  32'h0000_0006, 32'h0000_0006};
    vecs[8] = '{"ctrl_upper",    4'd0,  32'hFFFF_FFF8, 32'h0000_0000};
    vecs[9] = '{"status_idle",   4'd1,  32'hFFFF_FFFF, 32'h0000_0000};

    reset = 1'b1; s_address = '0; s_chipselect = 1'b0; s_write_n = 1'b1;
    s_writedata = '0; m_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_cs", {31'd0, m_chipselect}, 32'd0);
    checkOutput("rst_wn", {31'd0, m_write_n}, 32'd1);
    checkOutput("rst_wdata", m_writedata, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    checkReg("rst_period", 4'd2, 32'd1);
    checkReg("rst_length", 4'd3, 32'd4);
    checkReg("rst_ctrl", 4'd0, 32'd0);
    checkReg("rst_status", 4'd1, 32'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].wdata);
      checkReg(vecs[i].name, vecs[i].addr, vecs[i].exp);
    end

    // One-shot run of four patterns, PERIOD=3 -> 4-cycle spacing.
    applyStimulus(4'd4, 32'h01); applyStimulus(4'd5, 32'h02);
    applyStimulus(4'd6, 32'h04); applyStimulus(4'd7, 32'h08);
    applyStimulus(4'd2, 32'd3);  applyStimulus(4'd3, 32'd4);
    clearLog();
    applyStimulus(4'd0, 32'h5);
    t0 = cyc;
    waitIdle(60, "oneshot_idle");
    checkOutput("oneshot_count", log_data.size(), 32'd4);
    for (int i = 0; i < 4 && i < log_data.size(); i++) begin
      checkOutput("oneshot_data", log_data[i], exp_pat[i]);
      checkOutput("oneshot_cycle", log_cyc[i] - t0, 4 * i);
    end
    checkOutput("oneshot_irq", {31'd0, done_irq}, 32'd1);
    checkReg("oneshot_status", 4'd1, 32'h2);
    checkReg("oneshot_ctrl", 4'd0, 32'h4);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("oneshot_no_extra", log_data.size(), 32'd4);
    applyStimulus(4'd1, 32'd0);
    checkOutput("status_clear_irq", {31'd0, done_irq}, 32'd0);

    // Looping two-step run with PERIOD=0 -> 2-cycle spacing, then stop in HOLD.
    applyStimulus(4'd3, 32'd2); applyStimulus(4'd2, 32'd0);
    clearLog();
    applyStimulus(4'd0, 32'h3);
    t0 = cyc;
    waitWrites(5, 40, "loop_writes");
    for (int i = 0; i < 5 && i < log_data.size(); i++) begin
      checkOutput("loop_data", log_data[i], (i % 2 == 0) ? 32'h01 : 32'h02);
      checkOutput("loop_cycle", log_cyc[i] - t0, 2 * i);
    end
    n = 0;
    while (!m_chipselect && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("loop_sync", {31'd0, m_chipselect}, 32'd1);
    n = log_data.size() + 1;
    applyStimulus(4'd0, 32'h0);
    checkOutput("loop_stop_busy", {31'd0, busy}, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("loop_stop_writes", log_data.size(), n);
    readReg(4'd1, rd);
    checkOutput("loop_no_done", {30'd0, rd[1:0]}, 32'd0);

    // Waitrequest stall of 5 cycles on the first write; pattern rewritten mid-stall.
    applyStimulus(4'd3, 32'd2); applyStimulus(4'd2, 32'd2);
    clearLog();
    m_waitrequest = 1'b1;
    applyStimulus(4'd0, 32'h1);
    t0 = cyc;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        s_chipselect = 1'b0; s_write_n = 1'b1; s_writedata = '0;
      end
      checkOutput("stall_cs", {31'd0, m_chipselect}, 32'd1);
      checkOutput("stall_wn", {31'd0, m_write_n}, 32'd0);
      checkOutput("stall_addr", {30'd0, m_address}, 32'd0);
      checkOutput("stall_data", m_writedata, 32'h01);
      if (i == 1) begin
        s_chipselect = 1'b1; s_write_n = 1'b0; s_address = 4'd4; s_writedata = 32'h77;
      end
      @(posedge clk); #1;
    end
    m_waitrequest = 1'b0;
    waitIdle(30, "stall_idle");
    checkOutput("stall_count", log_data.size(), 32'd2);
    if (log_data.size() >= 2) begin
      checkOutput("stall_first_cycle", log_cyc[0] - t0, 32'd5);
      checkOutput("stall_first_data", log_data[0], 32'h01);
      checkOutput("stall_gap", log_cyc[1] - log_cyc[0], 32'd3);
      checkOutput("stall_second_data", log_data[1], 32'h02);
    end
    checkReg("stall_pattern0", 4'd4, 32'h77);
    applyStimulus(4'd1, 32'd0);
    applyStimulus(4'd4, 32'h01);

    // LENGTH=0 clamps to one step, LENGTH=9 clamps to four.
    applyStimulus(4'd2, 32'd1); applyStimulus(4'd3, 32'd0);
    clearLog();
    applyStimulus(4'd0, 32'h1);
    waitIdle(30, "len0_idle");
    checkOutput("len0_count", log_data.size(), 32'd1);
    applyStimulus(4'd3, 32'd9);
    clearLog();
    applyStimulus(4'd0, 32'h1);
    waitIdle(40, "len9_idle");
    checkOutput("len9_count", log_data.size(), 32'd4);
    if (log_data.size() == 4) checkOutput("len9_last", log_data[3], 32'h08);
    applyStimulus(4'd1, 32'd0);

    // RUN rewritten while busy must not restart; IRQ_EN from that write still lands.
    applyStimulus(4'd2, 32'd5); applyStimulus(4'd3, 32'd4);
    clearLog();
    applyStimulus(4'd0, 32'h1);
    waitWrites(2, 40, "rerun_wait");
    applyStimulus(4'd0, 32'h5);
    readReg(4'd1, rd);
    checkOutput("rerun_step", {28'd0, rd[11:8]}, 32'd1);
    checkOutput("rerun_busy", {31'd0, rd[0]}, 32'd1);
    checkReg("rerun_ctrl", 4'd0, 32'h5);
    waitIdle(80, "rerun_idle");
    checkOutput("rerun_count", log_data.size(), 32'd4);
    for (int i = 0; i < 4 && i < log_data.size(); i++)
      checkOutput("rerun_data", log_data[i], exp_pat[i]);
    checkOutput("rerun_irq", {31'd0, done_irq}, 32'd1);
    applyStimulus(4'd1, 32'd0);
    checkOutput("rerun_irq_clr", {31'd0, done_irq}, 32'd0);

    // STATUS write landing on the same edge that sets DONE: the set wins.
    applyStimulus(4'd2, 32'd1); applyStimulus(4'd3, 32'd1);
    applyStimulus(4'd0, 32'h5);
    @(posedge clk); #1;
    checkOutput("coinc_in_hold", {31'd0, busy & ~m_chipselect}, 32'd1);
    s_chipselect = 1'b1; s_write_n = 1'b0; s_address = 4'd1; s_writedata = '0;
    @(posedge clk); #1;
    s_chipselect = 1'b0; s_write_n = 1'b1;
    checkOutput("coinc_busy", {31'd0, busy}, 32'd0);
    checkOutput("coinc_irq", {31'd0, done_irq}, 32'd1);
    readReg(4'd1, rd);
    checkOutput("coinc_done", {31'd0, rd[1]}, 32'd1);

    // Asynchronous reset in the middle of a stalled write.
    m_waitrequest = 1'b1;
    applyStimulus(4'd0, 32'h7);
    checkOutput("pre_rst_cs", {31'd0, m_chipselect}, 32'd1);
    checkOutput("pre_rst_irq", {31'd0, done_irq}, 32'd1);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_cs", {31'd0, m_chipselect}, 32'd0);
    checkOutput("mid_rst_wn", {31'd0, m_write_n}, 32'd1);
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_irq", {31'd0, done_irq}, 32'd0);
    checkOutput("mid_rst_wdata", m_writedata, 32'd0);
    #10;
    reset = 1'b0;
    m_waitrequest = 1'b0;
    checkReg("mid_rst_period", 4'd2, 32'd1);
    checkReg("mid_rst_length", 4'd3, 32'd4);
    checkReg("mid_rst_pattern0", 4'd4, 32'd0);
    checkReg("mid_rst_ctrl", 4'd0, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
